// File: rtl/fifo_sequencer_pkg.sv
// Shared definitions for the FIFO load sequencer: FSM encoding and load modes.
package fifo_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_t;

  localparam logic FLAT    = 1'b0;
  localparam logic STAGGER = 1'b1;

  function automatic logic is_active(seq_state_t s);
    return (s == ST_LOAD) || (s == ST_DRAIN);
  endfunction

endpackage

// File: rtl/fifo_lane_window.sv
// Per-lane enable window: flat lanes open for [0, L), skewed lanes for [lane, lane+L).
module fifo_lane_window
  import fifo_sequencer_pkg::*;
#(
  parameter int LANE  = 0,
  parameter int CNT_W = 5,
  parameter int LEN_W = 5
) (
  input  logic [CNT_W-1:0] count,
  input  logic [LEN_W-1:0] len_l,
  input  logic             mode,
  output logic             en
);

  // One extra bit so lane+L cannot wrap for any legal parameter set.
  localparam int XW = CNT_W + 1;

  logic [XW-1:0] cnt_x;
  logic [XW-1:0] lo_x;
  logic [XW-1:0] hi_x;

  always_comb begin
    cnt_x = XW'(count);
    if (mode == STAGGER) begin
      lo_x = XW'(LANE);
      hi_x = XW'(LANE) + XW'(len_l);
    end else begin
      lo_x = '0;
      hi_x = XW'(len_l);
    end
    en = (cnt_x >= lo_x) && (cnt_x < hi_x);
  end

endmodule

// File: rtl/fifo_sequencer.sv
// FIFO load sequencer: drives per-lane FIFO enables and the weight write strobe
// for a flat or diagonally skewed load of L cycles per lane.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for start; validates len, flags rejected starts
// ST_LOAD  | count 0..L-1, weight writes while count < L-1
// ST_DRAIN | skewed mode only, count L..L+FIFO_WIDTH-2 while upper lanes finish
// ST_DONE  | single-cycle done pulse, then back to idle
module fifo_sequencer
  import fifo_sequencer_pkg::*;
#(
  parameter int FIFO_WIDTH = 16,
  parameter int MAX_LEN    = 16,
  localparam int LEN_W     = $clog2(MAX_LEN + 1),
  localparam int CNT_W     = $clog2(MAX_LEN + FIFO_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stagger,
  input  logic [LEN_W-1:0]      len,
  input  logic                  hold,
  input  logic                  abort,
  output logic [FIFO_WIDTH-1:0] fifo_en,
  output logic                  weight_write,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int XW = CNT_W + 1;
  localparam logic [LEN_W-1:0] MAX_LEN_V = LEN_W'(MAX_LEN);

  seq_state_t       state, state_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic [LEN_W-1:0] len_l, len_nxt;
  logic             mode_l, mode_nxt;
  logic             err_q, err_nxt;

  logic [XW-1:0]         cnt_x;
  logic [XW-1:0]         len_x;
  logic                  active;
  logic                  advance;
  logic                  len_ok;
  logic                  load_last;
  logic                  drain_last;
  logic [FIFO_WIDTH-1:0] lane_en;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      count  <= '0;
      len_l  <= '0;
      mode_l <= FLAT;
      err_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      count  <= count_nxt;
      len_l  <= len_nxt;
      mode_l <= mode_nxt;
      err_q  <= err_nxt;
    end
  end

  always_comb begin
    cnt_x      = XW'(count);
    len_x      = XW'(len_l);
    active     = is_active(state);
    advance    = active && !hold;
    len_ok     = (len != '0) && (len <= MAX_LEN_V);
    load_last  = (cnt_x + XW'(1)) == len_x;
    drain_last = (cnt_x + XW'(2)) == (len_x + XW'(FIFO_WIDTH));
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    len_nxt   = len_l;
    mode_nxt  = mode_l;
    err_nxt   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !abort) begin
          if (len_ok) begin
            state_nxt = ST_LOAD;
            count_nxt = '0;
            len_nxt   = len;
            mode_nxt  = stagger;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (!hold) begin
          count_nxt = count + CNT_W'(1);
          if (load_last) begin
            // A single lane has no skew to drain.
            state_nxt = (mode_l == STAGGER && FIFO_WIDTH > 1) ? ST_DRAIN : ST_DONE;
          end
        end
      end
      ST_DRAIN: begin
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (!hold) begin
          count_nxt = count + CNT_W'(1);
          if (drain_last) state_nxt = ST_DONE;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  for (genvar i = 0; i < FIFO_WIDTH; i++) begin : g_lane
    fifo_lane_window #(
      .LANE (i),
      .CNT_W(CNT_W),
      .LEN_W(LEN_W)
    ) u_lane (
      .count(count),
      .len_l(len_l),
      .mode (mode_l),
      .en   (lane_en[i])
    );
  end

  always_comb begin
    busy         = active;
    fifo_en      = advance ? lane_en : '0;
    weight_write = (state == ST_LOAD) && !hold && ((cnt_x + XW'(1)) < len_x);
    done         = (state == ST_DONE);
    err          = err_q;
  end

endmodule

// File: tb/tb_fifo_sequencer.sv
// Bench for fifo_sequencer: 16-lane and 4-lane instances share stimulus and are
// checked every cycle against a progress-index model, plus directed tables.
module tb_fifo_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, stagger, hold, abort;
  logic [4:0] len;
  logic [15:0] en16;
  logic        ww16, busy16, done16, err16;
  logic [3:0]  en4;
  logic        ww4, busy4, done4, err4;

  fifo_sequencer #(.FIFO_WIDTH(16), .MAX_LEN(16)) dut16 (
    .clk(clk), .reset(reset), .start(start), .stagger(stagger), .len(len),
    .hold(hold), .abort(abort), .fifo_en(en16), .weight_write(ww16),
    .busy(busy16), .done(done16), .err(err16));

  fifo_sequencer #(.FIFO_WIDTH(4), .MAX_LEN(16)) dut4 (
    .clk(clk), .reset(reset), .start(start), .stagger(stagger), .len(len),
    .hold(hold), .abort(abort), .fifo_en(en4), .weight_write(ww4),
    .busy(busy4), .done(done4), .err(err4));

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Model state per instance: index 0 = 16 lanes, 1 = 4 lanes.
  int width[2] = '{16, 4};
  bit m_act[2], m_done[2], m_err[2], m_stg[2];
  int m_t[2], m_len[2], m_total[2];

  logic [31:0] snap16, snap4;

  typedef struct {
    logic       st, sg;
    logic [4:0] ln;
    logic       hd, ab;
    logic [3:0] en;
    logic       ww, busy, done, err;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %08h expected %08h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] pack(logic [31:0] en, logic ww, logic b, logic d, logic e);
    return {en[27:0], ww, b, d, e};
  endfunction

  function automatic logic [31:0] live(int d);
    if (d == 0) return pack(32'(en16), ww16, busy16, done16, err16);
    return pack(32'(en4), ww4, busy4, done4, err4);
  endfunction

  // Enabled lanes at progress step t of a load of length l.
  function automatic logic [31:0] lane_mask(int w, int l, bit s, int t);
    logic [31:0] m = '0;
    for (int i = 0; i < w; i++)
      if (s ? (t >= i && t < i + l) : (t < l)) m[i] = 1'b1;
    return m;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_act[d] = 0; m_done[d] = 0; m_err[d] = 0; m_stg[d] = 0;
      m_t[d] = 0; m_len[d] = 0; m_total[d] = 0;
    end
  endtask

  task automatic cycle(input logic st, input logic sg, input logic [4:0] ln,
                       input logic hd, input logic ab);
    logic [31:0] exp_en, exp, act;
    bit nd, ne;
    start = st; stagger = sg; len = ln; hold = hd; abort = ab;
    #2;
    snap16 = live(0);
    snap4  = live(1);
    for (int d = 0; d < 2; d++) begin
      exp_en = (m_act[d] && !hd) ? lane_mask(width[d], m_len[d], m_stg[d], m_t[d]) : 32'd0;
      exp = pack(exp_en, m_act[d] && !hd && (m_t[d] < m_len[d] - 1), m_act[d], m_done[d], m_err[d]);
      act = (d == 0) ? snap16 : snap4;
      check((d == 0) ? "model_w16" : "model_w4", act, exp);
      nd = 0; ne = 0;
      if (m_act[d]) begin
        if (ab) m_act[d] = 0;
        else if (!hd) begin
          m_t[d]++;
          if (m_t[d] == m_total[d]) begin m_act[d] = 0; nd = 1; end
        end
      end else if (!m_done[d] && st && !ab) begin
        if (ln >= 1 && ln <= 16) begin
          m_act[d] = 1; m_t[d] = 0; m_len[d] = int'(ln); m_stg[d] = sg;
          m_total[d] = (sg && width[d] > 1) ? int'(ln) + width[d] - 1 : int'(ln);
        end else ne = 1;
      end
      m_done[d] = nd;
      m_err[d]  = ne;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 5'd0, 0, 0);
  endtask

  function automatic vec_t v(logic st, logic sg, logic [4:0] ln, logic hd, logic ab,
                             logic [3:0] en, logic ww, logic b, logic d, logic e);
    vec_t r;
    r.st = st; r.sg = sg; r.ln = ln; r.hd = hd; r.ab = ab;
    r.en = en; r.ww = ww; r.busy = b; r.done = d; r.err = e;
    return r;
  endfunction

  initial begin
    int en_cnt, ww_cnt, busy_cnt, done_cnt, done_at;

    // 4-lane skewed load, L=3 (start mid-run with other len/stagger is ignored)
    tbl.push_back(v(1, 1, 5'd3, 0, 0, 4'h0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 5'd0, 0, 0, 4'h1, 1, 1, 0, 0));
    tbl.push_back(v(1, 0, 5'd9, 0, 0, 4'h3, 1, 1, 0, 0));
    tbl.push_back(v(0, 0, 5'd0, 0, 0, 4'h7, 0, 1, 0, 0));
    tbl.push_back(v(0, 0, 5'd0, 0, 0, 4'hE, 0, 1, 0, 0));
    tbl.push_back(v(0, 0, 5'd0, 0, 0, 4'hC, 0, 1, 0, 0));
    tbl.push_back(v(0, 0, 5'd0, 0, 0, 4'h8, 0, 1, 0, 0));
    tbl.push_back(v(0, 0, 5'd0, 0, 0, 4'h0, 0, 0, 1, 0));
    tbl.push_back(v(0, 0, 5'd0, 0, 0, 4'h0, 0, 0, 0, 0));
    // 4-lane flat L=4 with a 2-cycle hold at count 1
    tbl.push_back(v(1, 0, 5'd4, 0, 0, 4'h0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 5'd0, 0, 0, 4'hF, 1, 1, 0, 0));
    tbl.push_back(v(0, 0, 5'd0, 1, 0, 4'h0, 0, 1, 0, 0));
    tbl.push_back(v(0, 0, 5'd0, 1, 0, 4'h0, 0, 1, 0, 0));
    tbl.push_back(v(0, 0, 5'd0, 0, 0, 4'hF, 1, 1, 0, 0));
    tbl.push_back(v(0, 0, 5'd0, 0, 0, 4'hF, 1, 1, 0, 0));
    tbl.push_back(v(0, 0, 5'd0, 0, 0, 4'hF, 0, 1, 0, 0));
    tbl.push_back(v(0, 0, 5'd0, 0, 0, 4'h0, 0, 0, 1, 0));
    tbl.push_back(v(0, 0, 5'd0, 0, 0, 4'h0, 0, 0, 0, 0));
    // rejected lengths, then abort beating start
    tbl.push_back(v(1, 0, 5'd0, 0, 0, 4'h0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 5'd0, 0, 0, 4'h0, 0, 0, 0, 1));
    tbl.push_back(v(1, 0, 5'd17, 0, 0, 4'h0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 5'd0, 0, 0, 4'h0, 0, 0, 0, 1));
    tbl.push_back(v(1, 1, 5'd3, 0, 1, 4'h0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 5'd0, 0, 0, 4'h0, 0, 0, 0, 0));

    model_reset();
    reset = 1'b0; start = 0; stagger = 0; len = '0; hold = 0; abort = 0;
    #12;
    check("reset_w16", live(0), 32'd0);
    check("reset_w4", live(1), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    foreach (tbl[k]) begin
      cycle(tbl[k].st, tbl[k].sg, tbl[k].ln, tbl[k].hd, tbl[k].ab);
      check($sformatf("table_row%0d", k), snap4,
            pack(32'(tbl[k].en), tbl[k].ww, tbl[k].busy, tbl[k].done, tbl[k].err));
    end
    idle(40);

    // 16-lane flat L=16
    cycle(1, 0, 5'd16, 0, 0);
    en_cnt = 0; ww_cnt = 0; busy_cnt = 0; done_at = -1;
    for (int k = 1; k <= 20; k++) begin
      cycle(0, 0, 5'd0, 0, 0);
      if (snap16[19:4] == 16'hFFFF) en_cnt++;
      if (snap16[3]) ww_cnt++;
      if (snap16[2]) busy_cnt++;
      if (snap16[1]) done_at = k;
    end
    check("flat16_en_cycles", 32'(en_cnt), 32'd16);
    check("flat16_ww_cycles", 32'(ww_cnt), 32'd15);
    check("flat16_busy_cycles", 32'(busy_cnt), 32'd16);
    check("flat16_done_cycle", 32'(done_at), 32'd17);
    idle(10);

    // 16-lane skewed L=16, abort at count 20, then a full rerun
    cycle(1, 1, 5'd16, 0, 0);
    for (int k = 1; k <= 20; k++) cycle(0, 0, 5'd0, 0, 0);
    cycle(0, 0, 5'd0, 0, 1);
    cycle(0, 0, 5'd0, 0, 0);
    check("abort_then_idle", snap16, 32'd0);
    done_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      cycle(0, 0, 5'd0, 0, 0);
      if (snap16[1]) done_cnt++;
    end
    check("abort_no_done", 32'(done_cnt), 32'd0);
    cycle(1, 1, 5'd16, 0, 0);
    busy_cnt = 0; done_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      cycle(0, 0, 5'd0, 0, 0);
      if (snap16[2]) busy_cnt++;
      if (snap16[1]) done_cnt++;
    end
    check("rerun_busy_cycles", 32'(busy_cnt), 32'd31);
    check("rerun_done_pulses", 32'(done_cnt), 32'd1);

    // reset in the middle of a flat run at count 5
    cycle(1, 0, 5'd16, 0, 0);
    for (int k = 0; k < 5; k++) cycle(0, 0, 5'd0, 0, 0);
    start = 0; hold = 0; abort = 0;
    #1;
    check("pre_reset_busy", 32'(busy16), 32'd1);
    reset = 1'b0;
    #1;
    check("async_reset_w16", live(0), 32'd0);
    check("async_reset_w4", live(1), 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    cycle(1, 0, 5'd4, 0, 0);
    cycle(0, 0, 5'd0, 0, 0);
    check("restart_accepted", 32'(snap16[2]), 32'd1);
    idle(8);

    // randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      cycle($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 18)), $urandom_range(0, 4) == 0,
            $urandom_range(0, 39) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
